// File: rtl/i2c_arb_if.sv
// i2c_arb_if: requester-side and shared-master-side signals of the i2c_arb arbiter
interface i2c_arb_if;
  logic        req0_start, req1_start;
  logic [3:0]  req0_type, req1_type;
  logic [31:0] req0_cmd, req1_cmd;
  logic        req0_status, req1_status;
  logic [15:0] req0_rd_data, req1_rd_data;
  logic        m_start;
  logic [3:0]  m_type;
  logic [31:0] m_cmd;
  logic        m_status;
  logic [15:0] m_rd_data;
  logic [1:0]  gnt;
  logic        timeout_flag;
  modport slave (
    input  req0_start, req1_start, req0_type, req1_type, req0_cmd, req1_cmd, m_status, m_rd_data,
    output req0_status, req1_status, req0_rd_data, req1_rd_data, m_start, m_type, m_cmd, gnt, timeout_flag
  );
  modport master (
    output req0_start, req1_start, req0_type, req1_type, req0_cmd, req1_cmd, m_status, m_rd_data,
    input  req0_status, req1_status, req0_rd_data, req1_rd_data, m_start, m_type, m_cmd, gnt, timeout_flag
  );
endinterface

// File: rtl/i2c_arb.sv
// i2c_arb: round-robin arbiter sharing one I2C master between two requesters; ack timeout enabled by I2C_ARB_TIMEOUT_EN
module i2c_arb #(
  parameter int TIMEOUT_CYCLES = 4000
) (
  input logic      clk,
  input logic      n_reset,
  i2c_arb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY, ABORT} state_t;
  state_t      state_q, state_d;
  logic        m_start_q, m_start_d;
  logic [3:0]  m_type_q, m_type_d;
  logic [31:0] m_cmd_q, m_cmd_d;
  logic [1:0]  status_q, status_d, gnt_q, gnt_d, armed_q, armed_d;
  logic [15:0] rd0_q, rd0_d, rd1_q, rd1_d;
  logic        last_q, last_d;
  logic [1:0]  start, want, own;
  logic        win;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tflag_q, tflag_d;
  assign bus.timeout_flag = tflag_q;
`else
  assign bus.timeout_flag = 1'b0;
`endif
  assign start = {bus.req1_start, bus.req0_start};
  assign want  = start & armed_q;
  assign win   = (want[0] & want[1]) ? ~last_q : want[1];
  assign own   = last_q ? 2'b10 : 2'b01;
  assign bus.m_start      = m_start_q;
  assign bus.m_type       = m_type_q;
  assign bus.m_cmd        = m_cmd_q;
  assign bus.gnt          = gnt_q;
  assign bus.req0_status  = status_q[0];
  assign bus.req1_status  = status_q[1];
  assign bus.req0_rd_data = rd0_q;
  assign bus.req1_rd_data = rd1_q;
  // next-state: grant in IDLE, wait for ack in ISSUE, wait for done in BUSY, two-cycle error pulse in ABORT
  always_comb begin
    state_d   = state_q;
    m_start_d = m_start_q;
    m_type_d  = m_type_q;
    m_cmd_d   = m_cmd_q;
    status_d  = status_q;
    gnt_d     = gnt_q;
    rd0_d     = rd0_q;
    rd1_d     = rd1_q;
    last_d    = last_q;
    armed_d   = armed_q | ~start;
`ifdef I2C_ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    tflag_d   = tflag_q;
`endif
    case (state_q)
      IDLE: if (!bus.m_status && |want) begin
        state_d   = ISSUE;
        m_start_d = 1'b1;
        last_d    = win;
        m_type_d  = win ? bus.req1_type : bus.req0_type;
        m_cmd_d   = win ? bus.req1_cmd : bus.req0_cmd;
        gnt_d     = win ? 2'b10 : 2'b01;
`ifdef I2C_ARB_TIMEOUT_EN
        cnt_d     = '0;
`endif
      end
      ISSUE: if (bus.m_status) begin
        state_d   = BUSY;
        m_start_d = 1'b0;
        status_d  = own;
      end
`ifdef I2C_ARB_TIMEOUT_EN
      else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        state_d   = ABORT;
        m_start_d = 1'b0;
        status_d  = own;
        rd0_d     = own[0] ? 16'hFFFF : rd0_q;
        rd1_d     = own[1] ? 16'hFFFF : rd1_q;
        tflag_d   = 1'b1;
        cnt_d     = '0;
      end else
        cnt_d = cnt_q + 1'b1;
`endif
      BUSY: if (!bus.m_status) begin
        state_d  = IDLE;
        status_d = 2'b00;
        gnt_d    = 2'b00;
        armed_d  = armed_d & ~own;
        rd0_d    = own[0] ? bus.m_rd_data : rd0_q;
        rd1_d    = own[1] ? bus.m_rd_data : rd1_q;
`ifdef I2C_ARB_TIMEOUT_EN
        tflag_d  = 1'b0;
`endif
      end
`ifdef I2C_ARB_TIMEOUT_EN
      ABORT: if (cnt_q == '0)
        cnt_d = CW'(1);
      else begin
        state_d  = IDLE;
        status_d = 2'b00;
        gnt_d    = 2'b00;
        armed_d  = armed_d & ~own;
      end
`endif
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset; reset arms both requesters and favours req0
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q   <= IDLE;
      m_start_q <= 1'b0;
      m_type_q  <= '0;
      m_cmd_q   <= '0;
      status_q  <= '0;
      gnt_q     <= '0;
      rd0_q     <= '0;
      rd1_q     <= '0;
      last_q    <= 1'b1;
      armed_q   <= 2'b11;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= '0;
      tflag_q   <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      m_start_q <= m_start_d;
      m_type_q  <= m_type_d;
      m_cmd_q   <= m_cmd_d;
      status_q  <= status_d;
      gnt_q     <= gnt_d;
      rd0_q     <= rd0_d;
      rd1_q     <= rd1_d;
      last_q    <= last_d;
      armed_q   <= armed_d;
`ifdef I2C_ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      tflag_q   <= tflag_d;
`endif
    end
  end
endmodule

// File: tb/tb_i2c_arb.sv
// tb_i2c_arb: directed vector table plus hand sequences for arbitration, turnaround, reset and timeout
module tb_i2c_arb;
  localparam logic [31:0] C0 = 32'h2C01_0000;
  localparam logic [31:0] C1 = 32'h3A02_0304;
  logic clk, n_reset;
  int n_chk, n_fail;
  i2c_arb_if bus();
  i2c_arb #(.TIMEOUT_CYCLES(16)) dut (.clk(clk), .n_reset(n_reset), .bus(bus.slave));
  typedef struct {
    logic r0, r1, ms;
    logic [15:0] rd;
    logic e_ms;
    logic [1:0] e_g;
    logic e_s0, e_s1;
    logic [15:0] e_d0, e_d1;
    logic [31:0] e_mc;
  } vec_t;
  vec_t tv[15];
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic step(input logic r0, input logic r1, input logic ms, input logic [15:0] rd);
    @(negedge clk);
    bus.req0_start = r0;
    bus.req1_start = r1;
    bus.m_status   = ms;
    bus.m_rd_data  = rd;
    @(posedge clk);
    #1;
  endtask
  task automatic check_all(input string n, input logic ems, input logic [1:0] eg, input logic es0, input logic es1,
                           input logic [15:0] ed0, input logic [15:0] ed1, input logic [31:0] emc);
    chk({n, ".m_start"}, 32'(bus.m_start), 32'(ems));
    chk({n, ".gnt"}, 32'(bus.gnt), 32'(eg));
    chk({n, ".req0_status"}, 32'(bus.req0_status), 32'(es0));
    chk({n, ".req1_status"}, 32'(bus.req1_status), 32'(es1));
    chk({n, ".req0_rd_data"}, 32'(bus.req0_rd_data), 32'(ed0));
    chk({n, ".req1_rd_data"}, 32'(bus.req1_rd_data), 32'(ed1));
    chk({n, ".m_cmd"}, bus.m_cmd, emc);
  endtask
  initial begin
    n_chk = 0;
    n_fail = 0;
    bus.req0_type = 4'd1;
    bus.req0_cmd  = C0;
    bus.req1_type = 4'd2;
    bus.req1_cmd  = C1;
    tv[0]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01, 1'b0, 1'b0, 16'h0000, 16'h0000, C0};
    tv[1]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 2'b01, 1'b1, 1'b0, 16'h0000, 16'h0000, C0};
    tv[2]  = '{1'b1, 1'b1, 1'b0, 16'h1234, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234, 16'h0000, C0};
    tv[3]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b10, 1'b0, 1'b0, 16'h1234, 16'h0000, C1};
    tv[4]  = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 2'b10, 1'b0, 1'b1, 16'h1234, 16'h0000, C1};
    tv[5]  = '{1'b1, 1'b1, 1'b0, 16'hABCD, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234, 16'hABCD, C1};
    tv[6]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234, 16'hABCD, C1};
    tv[7]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234, 16'hABCD, C1};
    tv[8]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 2'b00, 1'b0, 1'b0, 16'h1234, 16'hABCD, C1};
    tv[9]  = '{1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b01, 1'b0, 1'b0, 16'h1234, 16'hABCD, C0};
    tv[10] = '{1'b1, 1'b1, 1'b1, 16'h0000, 1'b0, 2'b01, 1'b1, 1'b0, 16'h1234, 16'hABCD, C0};
    tv[11] = '{1'b0, 1'b1, 1'b0, 16'h5555, 1'b0, 2'b00, 1'b0, 1'b0, 16'h5555, 16'hABCD, C0};
    tv[12] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 2'b10, 1'b0, 1'b0, 16'h5555, 16'hABCD, C1};
    tv[13] = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 2'b10, 1'b0, 1'b1, 16'h5555, 16'hABCD, C1};
    tv[14] = '{1'b0, 1'b0, 1'b0, 16'h0F0F, 1'b0, 2'b00, 1'b0, 1'b0, 16'h5555, 16'h0F0F, C1};
    n_reset = 1'b0;
    step(0, 0, 0, 16'h0);
    step(0, 0, 0, 16'h0);
    check_all("reset", 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    chk("reset.m_type", 32'(bus.m_type), 32'h0);
    chk("reset.timeout_flag", 32'(bus.timeout_flag), 32'h0);
    n_reset = 1'b1;
    for (int i = 0; i < 15; i++) begin
      step(tv[i].r0, tv[i].r1, tv[i].ms, tv[i].rd);
      check_all($sformatf("v%0d", i), tv[i].e_ms, tv[i].e_g, tv[i].e_s0, tv[i].e_s1, tv[i].e_d0, tv[i].e_d1, tv[i].e_mc);
      chk($sformatf("v%0d.timeout_flag", i), 32'(bus.timeout_flag), 32'h0);
    end
    step(0, 0, 0, 16'h0);
    chk("late.idle_gnt", 32'(bus.gnt), 32'h0);
    step(1, 0, 0, 16'h0);
    check_all("late.grant0", 1'b1, 2'b01, 1'b0, 1'b0, 16'h5555, 16'h0F0F, C0);
    chk("late.m_type0", 32'(bus.m_type), 32'd1);
    step(1, 0, 1, 16'h0);
    step(1, 1, 1, 16'h0);
    check_all("late.busy", 1'b0, 2'b01, 1'b1, 1'b0, 16'h5555, 16'h0F0F, C0);
    step(0, 1, 0, 16'h2222);
    check_all("late.done0", 1'b0, 2'b00, 1'b0, 1'b0, 16'h2222, 16'h0F0F, C0);
    step(0, 1, 0, 16'h0);
    check_all("late.grant1", 1'b1, 2'b10, 1'b0, 1'b0, 16'h2222, 16'h0F0F, C1);
    chk("late.m_type1", 32'(bus.m_type), 32'd2);
    step(0, 1, 1, 16'h0);
    step(0, 0, 0, 16'h3333);
    check_all("late.done1", 1'b0, 2'b00, 1'b0, 1'b0, 16'h2222, 16'h3333, C1);
    step(1, 0, 0, 16'h0);
    step(1, 0, 1, 16'h0);
    chk("rst.busy_status", 32'(bus.req0_status), 32'h1);
    n_reset = 1'b0;
    step(1, 1, 1, 16'h0);
    check_all("rst.mid", 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    chk("rst.mid.m_type", 32'(bus.m_type), 32'h0);
    chk("rst.mid.timeout_flag", 32'(bus.timeout_flag), 32'h0);
    n_reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 1, 16'h0);
      chk($sformatf("rst.hold%0d.gnt", i), 32'(bus.gnt), 32'h0);
      chk($sformatf("rst.hold%0d.m_start", i), 32'(bus.m_start), 32'h0);
    end
    step(0, 1, 0, 16'h0);
    check_all("rst.regrant", 1'b1, 2'b10, 1'b0, 1'b0, 16'h0, 16'h0, C1);
    step(0, 1, 1, 16'h0);
    step(0, 0, 0, 16'h7777);
    check_all("rst.done", 1'b0, 2'b00, 1'b0, 1'b0, 16'h0, 16'h7777, C1);
`ifdef I2C_ARB_TIMEOUT_EN
    step(1, 0, 0, 16'h0);
    check_all("to.grant", 1'b1, 2'b01, 1'b0, 1'b0, 16'h0, 16'h7777, C0);
    for (int i = 0; i < 15; i++) begin
      step(1, 0, 0, 16'h0);
      chk($sformatf("to.wait%0d.m_start", i), 32'(bus.m_start), 32'h1);
    end
    step(1, 0, 0, 16'h0);
    check_all("to.abort1", 1'b0, 2'b01, 1'b1, 1'b0, 16'hFFFF, 16'h7777, C0);
    chk("to.abort1.flag", 32'(bus.timeout_flag), 32'h1);
    step(0, 0, 0, 16'h0);
    chk("to.abort2.status", 32'(bus.req0_status), 32'h1);
    step(0, 0, 0, 16'h0);
    check_all("to.end", 1'b0, 2'b00, 1'b0, 1'b0, 16'hFFFF, 16'h7777, C0);
    chk("to.end.flag", 32'(bus.timeout_flag), 32'h1);
    step(0, 1, 0, 16'h0);
    chk("to.next.gnt", 32'(bus.gnt), 32'h2);
    step(0, 1, 1, 16'h0);
    chk("to.next.flag_held", 32'(bus.timeout_flag), 32'h1);
    step(0, 0, 0, 16'h4444);
    check_all("to.next.done", 1'b0, 2'b00, 1'b0, 1'b0, 16'hFFFF, 16'h4444, C1);
    chk("to.next.flag_clear", 32'(bus.timeout_flag), 32'h0);
`else
    step(1, 0, 0, 16'h0);
    check_all("nto.grant", 1'b1, 2'b01, 1'b0, 1'b0, 16'h0, 16'h7777, C0);
    for (int i = 0; i < 40; i++) step(1, 0, 0, 16'h0);
    check_all("nto.wait", 1'b1, 2'b01, 1'b0, 1'b0, 16'h0, 16'h7777, C0);
    chk("nto.wait.flag", 32'(bus.timeout_flag), 32'h0);
    step(1, 0, 1, 16'h0);
    chk("nto.ack.status", 32'(bus.req0_status), 32'h1);
    step(0, 0, 0, 16'h4444);
    check_all("nto.done", 1'b0, 2'b00, 1'b0, 1'b0, 16'h4444, 16'h7777, C0);
    chk("nto.done.flag", 32'(bus.timeout_flag), 32'h0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/i2c_arb.md
I2C_ARB -- requirements
Module: i2c_arb

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 4000: cycles allowed from m_start assertion to m_status rising.
REQ-002 SHALL have port clk  in  1  100 MHz system clock.
REQ-003 SHALL have port n_reset  in  1  reset; synchronous, active-low; clock clk.
REQ-004 SHALL have ports req0_start / req1_start  in  1  transaction request (req0 = CAM, req1 = autonomous poller).
REQ-005 SHALL have ports req0_type / req1_type  in  4  I2C type (0 write, 1 read, 2 read with repeated start).
REQ-006 SHALL have ports req0_cmd / req1_cmd  in  32  {arg1,arg0,pay1,pay0}.
REQ-007 SHALL have ports req0_status / req1_status  out  1  per-requester busy handshake.
REQ-008 SHALL have ports req0_rd_data / req1_rd_data  out  16  {data0,data1} latched at completion.
REQ-009 SHALL have ports m_start out 1; m_type out 4; m_cmd out 32; m_status in 1; m_rd_data in 16; these connect to the single shared I2C master.
REQ-010 SHALL have ports gnt  out  2  one-hot current owner; timeout_flag  out  1  sticky error.

Function
REQ-011 SHALL implement FSM IDLE -> ISSUE -> BUSY -> IDLE, plus ABORT when timeout is compiled in.
REQ-012 IDLE: SHALL grant only when m_status=0 and at least one armed requester has start=1.
- Requester is armed when its start has been sampled 0 since its last completion.
- Reset arms both requesters.
REQ-013 Both requesting: SHALL round-robin and grant the requester not granted last.
- last_grant resets to 1, so req0 wins the first tie.
REQ-014 On grant at edge N:
- m_type/m_cmd are latched from the winner, and gnt is set.
- m_start=1 from cycle N+1; state goes to ISSUE.
- m_type/m_cmd are held stable until return to IDLE.
REQ-015 ISSUE: on m_status=1, SHALL set m_start=0 and owner status=1 at the next edge, and go to BUSY.
REQ-016 BUSY: on m_status=0, at the next edge SHALL:
- latch m_rd_data into the owner's rd_data;
- clear owner status, gnt, and timeout_flag;
- disarm the owner and return to IDLE.
REQ-017 The non-owner's status SHALL stay 0 and its rd_data SHALL stay unchanged throughout.
REQ-018 Requests arriving during ISSUE/BUSY SHALL wait; they are not lost while start stays high.
REQ-019 Minimum turnaround SHALL be one IDLE cycle between transactions.
REQ-020 Requester dropping start mid-transaction SHALL NOT abort the master transaction.

Reset
REQ-021 On n_reset=0 at a clk edge, the block SHALL set:
- state=IDLE, m_start=0, m_type=0, m_cmd=0;
- req*_status=0, req*_rd_data=0;
- gnt=0, timeout_flag=0, last_grant=1, timeout counter=0.
REQ-022 Reset mid-transaction SHALL abandon ownership; the master is not re-granted until m_status=0 (REQ-012).

Configuration
REQ-023 With macro I2C_ARB_TIMEOUT_EN defined, ISSUE SHALL count cycles.
- On reaching TIMEOUT_CYCLES with m_status still 0: m_start=0, go to ABORT.
- ABORT: owner status=1 for exactly 2 cycles, then 0; owner rd_data=16'hFFFF; timeout_flag=1.
- Owner is disarmed; state returns to IDLE.
REQ-024 Without I2C_ARB_TIMEOUT_EN, ISSUE SHALL wait indefinitely, no counter is synthesized, and timeout_flag SHALL be tied 0.

Verification
REQ-025 Single request: req0 read, cmd 32'h2C_01_00_00, master model returns 16'h1234.
- Expect m_start at N+1.
- Expect req0_status high then low.
- Expect req0_rd_data=16'h1234, with req1 outputs untouched.
REQ-026 Simultaneous req0+req1 after reset: expect order req0, req1. A second simultaneous pair expects req0 then req1 again, since last_grant=1 after the second.
REQ-027 req1 raised during req0 BUSY: expect req1 granted exactly 1 IDLE cycle after req0 completes, with m_cmd changing only then.
REQ-028 Requester holds start high after completion: expect no second grant until start goes 0 then 1.
REQ-029 Timeout enabled, TIMEOUT_CYCLES=16, master never acks:
- Expect m_start low after 16 cycles.
- Expect status pulse of 2 cycles, rd_data=16'hFFFF, timeout_flag=1.
- Expect the next good transaction to clear timeout_flag.
REQ-030 n_reset asserted in BUSY with m_status still 1: expect all outputs at reset values. Expect no grant until m_status falls, then a pending request granted.
